// File: rtl/instruct_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// master = fetch/decode side, slave = the queue itself.
interface instruct_fetch_queue_if #(
    parameter int unsigned MAX_LENGTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [MAX_LENGTH-1:0] in_pc;
    logic [MAX_LENGTH-1:0] in_instruction;
    logic                  full;
    logic                  out_ready;
    logic                  out_valid;
    logic [MAX_LENGTH-1:0] out_pc;
    logic [MAX_LENGTH-1:0] out_instruction;
    logic [CNT_W-1:0]      count;

    modport master (
        output in_valid, in_pc, in_instruction, out_ready,
        input  full, out_valid, out_pc, out_instruction, count
    );

    modport slave (
        input  in_valid, in_pc, in_instruction, out_ready,
        output full, out_valid, out_pc, out_instruction, count
    );
endinterface

// File: rtl/instruct_fetch_queue.sv
// First-word-fall-through {pc, instruction} queue between fetch and decode.
// Back-pressures fetch via full; a taken branch (flush) empties it in one cycle.
module instruct_fetch_queue #(
    parameter int unsigned MAX_LENGTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    instruct_fetch_queue_if.slave  q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [MAX_LENGTH-1:0] mem_pc    [DEPTH];
    logic [MAX_LENGTH-1:0] mem_instr [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  full_q;
    logic                  head_valid;
    logic                  push;
    logic                  pop;

    // Handshake qualification; flush overrides both directions
    always_comb begin
        head_valid = (cnt != '0);
        push       = q.in_valid & ~full_q & ~flush;
        pop        = head_valid & q.out_ready & ~flush;
        cnt_nxt    = cnt;
        if (flush) begin
            cnt_nxt = '0;
        end else if (push && !pop) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else begin
            cnt    <= cnt_nxt;
            full_q <= (cnt_nxt == FULL_CNT);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem_pc[wr_ptr]    <= q.in_pc;
                    mem_instr[wr_ptr] <= q.in_instruction;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Empty queue presents a NOP at pc 0 to decode
    assign q.out_valid       = head_valid;
    assign q.out_pc          = head_valid ? mem_pc[rd_ptr]    : '0;
    assign q.out_instruction = head_valid ? mem_instr[rd_ptr] : '0;
    assign q.full            = full_q;
    assign q.count           = cnt;
endmodule

// File: doc/instruct_fetch_queue.md
Name: instruct_fetch_queue

Overview:
- Small first-word-fall-through buffer between the instruction fetch stage and the decode stage.
- Captures {pc, instruction} pairs produced by fetch and presents the oldest pair to decode.
- Absorbs decode stalls without immediately freezing the PC register, and back-pressures fetch through `full` (drives fetch `freeze`).
- Discarded in one cycle on a taken branch (`flush`, driven by `brTaken`).

Parameters:
- MAX_LENGTH, 32, datapath width of pc and instruction fields (matches `MAX_LENGTH` in defines.v).
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, log2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  taken branch; discard all entries
- in_valid  input  1  fetch presents a valid pair this cycle
- in_pc  input  MAX_LENGTH  PC of fetched instruction
- in_instruction  input  MAX_LENGTH  fetched instruction word
- full  output  1  queue holds DEPTH entries; fetch must freeze
- out_ready  input  1  decode accepts head entry this cycle
- out_valid  output  1  head entry valid
- out_pc  output  MAX_LENGTH  PC of head entry
- out_instruction  output  MAX_LENGTH  instruction of head entry, or 0 (NOP) when empty
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH-entry arrays of pc and instruction, write pointer wr_ptr, read pointer rd_ptr, occupancy register cnt. All state is registered on the rising edge of clk.
- Reset (asynchronous, immediate):
  - wr_ptr = 0, rd_ptr = 0, cnt = 0, all storage entries = 0.
  - Outputs: full = 0, out_valid = 0, out_pc = 0, out_instruction = 0, count = 0.
- push = in_valid & ~full & ~flush.
  - `full` is the registered state (cnt == DEPTH) only; it never depends combinationally on out_ready.
  - A push is refused when full, even if a pop occurs in the same cycle.
- pop = out_valid & out_ready & ~flush.
- Flush has highest priority. On any edge with flush = 1:
  - wr_ptr = rd_ptr = cnt = 0.
  - Any same-cycle push and pop are ignored.
  - Storage contents need not be cleared.
- Push: write in_pc and in_instruction at wr_ptr; wr_ptr + 1 modulo DEPTH (natural wrap).
- Pop: rd_ptr + 1 modulo DEPTH.
- Occupancy update:
  - cnt + 1 on push only.
  - cnt − 1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Simultaneous push and pop at cnt = 1:
  - The old head leaves.
  - The new entry becomes head next cycle; no bubble.
- Simultaneous push and pop at cnt = 0 is impossible (pop requires out_valid).
- Output path is combinational from state:
  - out_valid = (cnt != 0).
  - out_pc and out_instruction come from entry rd_ptr when out_valid, else 0.
  - Latency is one cycle: a pair pushed at edge N is visible at the outputs after edge N.
  - There is no fall-through of in_* to out_* in the same cycle.
- full = (cnt == DEPTH); count = cnt.
- Pointer wrap: after DEPTH pushes and DEPTH pops, both pointers return to 0 with cnt = 0, and ordering is preserved across wrap.
- in_valid while full: the data is dropped by this block. The fetch stage must hold its PC via freeze = full, so no instruction is lost.
- out_ready while empty: no effect.
- Reset asserted mid-operation: all state clears at once regardless of clk. The first push after reset deasserts lands in entry 0.

Test Plan:
- Reset, then push pc 0x0,0x4,0x8 with instr 0xA0,0xA1,0xA2, out_ready = 0 -> count = 3, out_valid = 1, out_pc = 0x0, out_instruction = 0xA0, full = 0.
- From the previous state, push 0xC (0xA3) -> full = 1. A further in_valid with pc 0x10 is refused and count stays 4. Then out_ready = 1 for 4 cycles -> out_pc sequence 0x0,0x4,0x8,0xC, then out_valid = 0 and out_instruction = 0.
- Continuous in_valid = 1 and out_ready = 1 for 12 cycles from empty -> count steady at 1 after the first cycle, out_pc increments by 4 each cycle, pointers wrap 3 times with no loss or reorder.
- With count = 3, assert flush together with in_valid (pc 0x40) and out_ready -> next cycle count = 0 and out_valid = 0. Following push of pc 0x80 appears at the head with count = 1; 0x40 is never output.
- Assert reset asynchronously between clock edges with count = 2 -> outputs go to 0 and count to 0 before the next edge. Push after release is written to entry 0 and read back correctly.
- With count = 1 (pc 0x20), push pc 0x24 and pop in the same cycle -> next cycle count = 1, out_pc = 0x24, full = 0.
